lbp_hist: RTL and testbench
===========================

LBP_HIST -- requirements
Module: lbp_hist

Interface
REQ-001 SHALL have clk  input  1  rising-edge clock.
REQ-002 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have lbp_valid  input  1  LBP sample strobe; one sample per asserted cycle.
REQ-004 SHALL have lbp_addr  input  14  pixel address of the sample: row = addr[13:7], col = addr[6:0].
REQ-005 SHALL have lbp_data  input  8  LBP code.
REQ-006 SHALL have lbp_finish  input  1  upstream finish; level, sampled every cycle.
REQ-007 SHALL have hist_valid  output  1  bin-readout word is valid.
REQ-008 SHALL have hist_ready  input  1  downstream accepts the readout word.
REQ-009 SHALL have hist_addr  output  8  bin index of the readout word.
REQ-010 SHALL have hist_data  output  14  bin count of the readout word.
REQ-011 SHALL have hist_done  output  1  all bins read out; sticky until reset.
REQ-012 SHALL have drop_err  output  1  sticky flag: a sample arrived while it could not be accepted.

Function
REQ-013 SHALL implement states CLEAR -> ACCUM -> DRAIN -> DUMP -> DONE; reset enters CLEAR.
REQ-014 CLEAR SHALL zero bins 0..255, one bin per cycle, then go to ACCUM (256 cycles after reset release).
REQ-015 A lbp_valid in CLEAR, DRAIN, DUMP or DONE SHALL be discarded and SHALL set drop_err.
REQ-016 ACCUM SHALL ignore border samples (row 0, row 127, col 0, col 127) without setting drop_err.
REQ-017 For each accepted sample, ACCUM SHALL increment bin[map(lbp_data)] by 1, saturating at 16383.
REQ-018 Updates SHALL use a 2-stage read/write pipeline and accept one sample per cycle.
REQ-019 Back-to-back samples to the same bin SHALL be forwarded so that no increment is lost.
REQ-020 lbp_finish=1 in ACCUM SHALL move the block to DRAIN; a sample in that same cycle SHALL still be counted.
REQ-021 DRAIN SHALL last 2 cycles, until the pipeline is empty, then go to DUMP.
REQ-022 DUMP SHALL present bins 0..NBINS-1 in ascending order, with hist_addr = bin index.
REQ-023 A word SHALL transfer when hist_valid && hist_ready; the next word follows on the next cycle at the earliest.
REQ-024 hist_addr and hist_data SHALL hold stable while hist_valid=1 and hist_ready=0.
REQ-025 After bin NBINS-1 transfers, hist_valid SHALL drop, hist_done SHALL rise on the next cycle, and the state SHALL be DONE.
REQ-026 DONE SHALL hold until reset.
REQ-027 lbp_finish SHALL be ignored outside ACCUM.

Reset
REQ-028 Reset SHALL asynchronously clear the state to CLEAR and clear all counters and pipeline valids.
REQ-029 Reset SHALL drive hist_valid=0, hist_addr=0, hist_data=0, hist_done=0, drop_err=0.
REQ-030 Bin storage SHALL NOT be reset directly; it is zeroed by CLEAR.
REQ-031 Reset mid-ACCUM or mid-DUMP SHALL discard all counts and restart with CLEAR.

Configuration
REQ-032 Macro LBP_HIST_UNIFORM_EN SHALL select the bin mapping.
REQ-033 When LBP_HIST_UNIFORM_EN is defined, NBINS=59:
- codes with at most 2 circular 0/1 transitions are uniform;
- the 58 uniform codes map to bins 0..57 in ascending code order;
- all other codes map to bin 58.
REQ-034 When LBP_HIST_UNIFORM_EN is undefined, NBINS=256 and map(code)=code.
REQ-035 CLEAR SHALL always take 256 cycles, whether or not the macro is defined.

Structure
REQ-036 Package lbp_pkg SHALL hold IMG_W=128, IMG_H=128, CNT_W=14, CNT_MAX=16383, the state enum and NBINS.
REQ-037 Sub-module lbp_hist_ram SHALL hold the bin storage: 256x14, 1 read and 1 write port, synchronous write, registered read.
REQ-038 The uniform mapping SHALL be a pure function in lbp_pkg.

Verification
REQ-039 Scenario, reset release: reset release -> hist_valid=0 for 256 cycles; a lbp_valid at cycle 10 sets drop_err=1.
REQ-040 Scenario, back-to-back same bin: 15876 interior samples, all code 0x00, back-to-back -> dump shows bin0=15876 and all other bins 0.
REQ-041 Scenario, border filtering: samples at addr 128 (col 0) and 255 (col 127) -> not counted, drop_err=0.
REQ-042 Scenario, DUMP backpressure: hist_ready toggling 1010... -> 256 words, each held stable while stalled, addresses 0..255 in order; hist_done=1 one cycle after the last transfer.
REQ-043 Scenario, uniform mapping (LBP_HIST_UNIFORM_EN defined): codes 0x00, 0xFF, 0x05 -> bin0=1, bin57=1, bin58=1.
REQ-044 Scenario, reset mid-DUMP: reset asserted at word 100 -> outputs are at reset values; a rerun with 1 sample of code 0x03 dumps bin3=1 and all other bins 0.

Source files
------------

// File: rtl/lbp_pkg.sv
// Shared types, sizes and the LBP code-to-bin mapping for the LBP histogram block.
// Macro LBP_HIST_UNIFORM_EN selects the 59-bin uniform-pattern mapping instead of 256 raw bins.
package lbp_pkg;

    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int CNT_W = 14;
    localparam logic [CNT_W-1:0] CNT_MAX = 14'd16383;

`ifdef LBP_HIST_UNIFORM_EN
    localparam int NBINS = 59;
`else
    localparam int NBINS = 256;
`endif

    typedef enum logic [2:0] {
        S_CLEAR,
        S_ACCUM,
        S_DRAIN,
        S_DUMP,
        S_DONE
    } state_t;

    // A code is uniform when its circular bit string has at most two 0/1 transitions.
    function automatic logic is_uniform(input logic [7:0] code);
        logic [7:0] t;
        int n;
        t = code ^ {code[6:0], code[7]};
        n = 0;
        for (int i = 0; i < 8; i++) n += int'(t[i]);
        return n <= 2;
    endfunction

    // Rank of a uniform code among all uniform codes; everything else shares bin 58.
    function automatic logic [7:0] uniform_bin(input logic [7:0] code);
        logic [7:0] r;
        r = '0;
        if (!is_uniform(code)) return 8'd58;
        for (int j = 0; j < 256; j++)
            if (j < int'(code) && is_uniform(8'(j))) r = r + 8'd1;
        return r;
    endfunction

    function automatic logic [7:0] bin_map(input logic [7:0] code);
`ifdef LBP_HIST_UNIFORM_EN
        return uniform_bin(code);
`else
        return code;
`endif
    endfunction

endpackage

// File: rtl/lbp_hist_if.sv
// Sample input stream and bin readout stream of the LBP histogram block.
// master = sample producer / readout consumer, slave = histogram block.
interface lbp_hist_if;
    import lbp_pkg::*;

    logic             lbp_valid;
    logic [13:0]      lbp_addr;
    logic [7:0]       lbp_data;
    logic             lbp_finish;
    logic             hist_valid;
    logic             hist_ready;
    logic [7:0]       hist_addr;
    logic [CNT_W-1:0] hist_data;

    modport master (
        output lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
        input  hist_valid, hist_addr, hist_data
    );

    modport slave (
        input  lbp_valid, lbp_addr, lbp_data, lbp_finish, hist_ready,
        output hist_valid, hist_addr, hist_data
    );

endinterface

// File: rtl/lbp_hist_ram.sv
// Bin storage: 256 x CNT_W, one write port, one registered read port (read returns pre-write data).
module lbp_hist_ram
    import lbp_pkg::*;
(
    input  logic             clk,
    input  logic             we,
    input  logic [7:0]       waddr,
    input  logic [CNT_W-1:0] wdata,
    input  logic [7:0]       raddr,
    output logic [CNT_W-1:0] rdata
);

    logic [CNT_W-1:0] mem [0:255];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lbp_hist.sv
// LBP histogram: clears bins, accumulates interior samples, then streams the bins out.
// Macro LBP_HIST_UNIFORM_EN selects the uniform-pattern bin mapping (59 bins).
module lbp_hist
    import lbp_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    lbp_hist_if.slave bus,
    output logic      hist_done,
    output logic      drop_err
);

    state_t           state;
    logic [7:0]       clr_cnt;
    logic             drain_cnt;

    // accumulate pipeline: stage 0 reads the bin, stage 1 adds and writes back
    logic [6:0]       row, col;
    logic             interior;
    logic             s0_vld;
    logic [7:0]       s0_bin;
    logic             s1_vld;
    logic [7:0]       s1_bin;
    logic             fwd;
    logic [CNT_W-1:0] last_wdata;
    logic [CNT_W-1:0] s1_old, s1_new;

    // readout
    logic [8:0]       dump_idx;
    logic             rd_pend;
    logic [7:0]       rd_tag;
    logic             out_free, load, issue, last_xfer;
    logic             hist_valid_q;
    logic [7:0]       hist_addr_q;
    logic [CNT_W-1:0] hist_data_q;

    // RAM ports
    logic             ram_we;
    logic [7:0]       ram_waddr, ram_raddr;
    logic [CNT_W-1:0] ram_wdata, ram_rdata;

    assign row      = bus.lbp_addr[13:7];
    assign col      = bus.lbp_addr[6:0];
    assign interior = (row != 7'd0) && (row != 7'(IMG_H - 1)) &&
                      (col != 7'd0) && (col != 7'(IMG_W - 1));
    assign s0_vld   = bus.lbp_valid && (state == S_ACCUM) && interior;
    assign s0_bin   = bin_map(bus.lbp_data);

    // The previous write to the same bin is not yet visible in the RAM read data.
    assign s1_old = fwd ? last_wdata : ram_rdata;
    assign s1_new = (s1_old == CNT_MAX) ? s1_old : s1_old + {{(CNT_W-1){1'b0}}, 1'b1};

    assign out_free  = !hist_valid_q || bus.hist_ready;
    assign load      = rd_pend && out_free;
    assign issue     = (!rd_pend || load) && (dump_idx < 9'(NBINS));
    assign last_xfer = hist_valid_q && bus.hist_ready && (hist_addr_q == 8'(NBINS - 1));

    assign ram_we    = (state == S_CLEAR) || s1_vld;
    assign ram_waddr = (state == S_CLEAR) ? clr_cnt : s1_bin;
    assign ram_wdata = (state == S_CLEAR) ? '0 : s1_new;
    // While stalled the pending word is re-read so its read data stays put.
    assign ram_raddr = (state != S_DUMP) ? s0_bin :
                       issue             ? dump_idx[7:0] : rd_tag;

    assign bus.hist_valid = hist_valid_q;
    assign bus.hist_addr  = hist_addr_q;
    assign bus.hist_data  = hist_data_q;

    lbp_hist_ram u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        s1_bin     <= s0_bin;
        last_wdata <= s1_new;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_CLEAR;
            clr_cnt      <= '0;
            drain_cnt    <= 1'b0;
            s1_vld       <= 1'b0;
            fwd          <= 1'b0;
            dump_idx     <= '0;
            rd_pend      <= 1'b0;
            rd_tag       <= '0;
            hist_valid_q <= 1'b0;
            hist_addr_q  <= '0;
            hist_data_q  <= '0;
            hist_done    <= 1'b0;
            drop_err     <= 1'b0;
        end else begin
            s1_vld <= s0_vld;
            fwd    <= s0_vld && s1_vld && (s0_bin == s1_bin);
            if (bus.lbp_valid && state != S_ACCUM) drop_err <= 1'b1;

            case (state)
                S_CLEAR: begin
                    clr_cnt <= clr_cnt + 8'd1;
                    if (clr_cnt == 8'd255) state <= S_ACCUM;
                end
                S_ACCUM: begin
                    if (bus.lbp_finish) begin
                        state     <= S_DRAIN;
                        drain_cnt <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    drain_cnt <= 1'b1;
                    if (drain_cnt) state <= S_DUMP;
                end
                S_DUMP: begin
                    if (issue) begin
                        rd_pend  <= 1'b1;
                        rd_tag   <= dump_idx[7:0];
                        dump_idx <= dump_idx + 9'd1;
                    end else if (load) begin
                        rd_pend <= 1'b0;
                    end

                    if (load) begin
                        hist_valid_q <= 1'b1;
                        hist_addr_q  <= rd_tag;
                        hist_data_q  <= ram_rdata;
                    end else if (hist_valid_q && bus.hist_ready) begin
                        hist_valid_q <= 1'b0;
                    end

                    if (last_xfer) begin
                        state     <= S_DONE;
                        hist_done <= 1'b1;
                    end
                end
                S_DONE: ;
                default: state <= S_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_hist.sv
// Scoreboard bench for lbp_hist: directed sample streams, expected bins queued at finish,
// a negedge monitor pops and compares every readout word.
module tb_lbp_hist;
    import lbp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic hist_done, drop_err;

    lbp_hist_if bus();

    lbp_hist dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .hist_done (hist_done),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [13:0] data;
    } word_t;

    int    checks = 0;
    int    errors = 0;
    int    words_seen = 0;
    int    exp_bins [256];
    word_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Hand-derived bin index for the codes this bench uses.
    function automatic int map_code(input logic [7:0] c);
`ifdef LBP_HIST_UNIFORM_EN
        case (c)
            8'h00:   return 0;
            8'h01:   return 1;
            8'h03:   return 3;
            8'h10:   return 11;
            8'h20:   return 16;
            8'hFF:   return 57;
            default: return 58;
        endcase
`else
        return int'(c);
`endif
    endfunction

    function automatic logic [13:0] pix(input int r, input int c);
        return {7'(r), 7'(c)};
    endfunction

    // ---------------- monitor ----------------
    logic  stall_prev = 1'b0;
    logic  last_prev  = 1'b0;
    word_t held;
    word_t w;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
            last_prev  = 1'b0;
        end else begin
            if (last_prev) begin
                check("done_after_last", 32'(hist_done), 32'(1));
                check("valid_after_last", 32'(bus.hist_valid), 32'(0));
                last_prev = 1'b0;
            end
            if (stall_prev) begin
                check("stall_valid", 32'(bus.hist_valid), 32'(1));
                check("stall_addr", 32'(bus.hist_addr), 32'(held.addr));
                check("stall_data", 32'(bus.hist_data), 32'(held.data));
            end
            stall_prev = bus.hist_valid && !bus.hist_ready;
            held       = {bus.hist_addr, bus.hist_data};
            if (bus.hist_valid && bus.hist_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: addr %0d data %0d with empty queue",
                             bus.hist_addr, bus.hist_data);
                end else begin
                    w = exp_q.pop_front();
                    check("word_addr", 32'(bus.hist_addr), 32'(w.addr));
                    check("word_data", 32'(bus.hist_data), 32'(w.data));
                end
                words_seen++;
                if (bus.hist_addr == 8'(NBINS - 1)) last_prev = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lbp_valid  = 1'b0;
        bus.lbp_addr   = '0;
        bus.lbp_data   = '0;
        bus.lbp_finish = 1'b0;
        bus.hist_ready = 1'b0;
    endtask

    task automatic restart();
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) exp_bins[i] = 0;
        words_seen = 0;
    endtask

    task automatic wait_clear();
        repeat (260) step();
    endtask

    task automatic send(input logic [13:0] a, input logic [7:0] d, input bit fin);
        bus.lbp_valid  = 1'b1;
        bus.lbp_addr   = a;
        bus.lbp_data   = d;
        bus.lbp_finish = fin;
        step();
        bus.lbp_valid  = 1'b0;
        bus.lbp_finish = 1'b0;
    endtask

    task automatic finish_only();
        bus.lbp_finish = 1'b1;
        step();
        bus.lbp_finish = 1'b0;
    endtask

    task automatic push_expected();
        for (int i = 0; i < NBINS; i++) exp_q.push_back({8'(i), 14'(exp_bins[i])});
    endtask

    task automatic run_dump(input bit toggle, input int stop_at);
        int n;
        bit ok;
        ok = 1'b0;
        bus.hist_ready = 1'b1;
        for (n = 0; n < 2000; n++) begin
            step();
            if (toggle) bus.hist_ready = ~bus.hist_ready;
            if (hist_done) begin ok = 1'b1; break; end
            if (stop_at > 0 && words_seen >= stop_at) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL dump_timeout: no completion after %0d cycles, words %0d", n, words_seen);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hist_valid"}, 32'(bus.hist_valid), 32'(0));
        check({tag, "_hist_addr"},  32'(bus.hist_addr),  32'(0));
        check({tag, "_hist_data"},  32'(bus.hist_data),  32'(0));
        check({tag, "_hist_done"},  32'(hist_done),      32'(0));
        check({tag, "_drop_err"},   32'(drop_err),       32'(0));
    endtask

    // ---------------- scenarios ----------------
    initial begin
        bit seen_valid;
        int k;

        // reset release: no output during CLEAR, a sample in CLEAR is dropped
        reset = 1'b1;
        idle();
        step();
        check_reset_outputs("rst");
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int cyc = 0; cyc < 256; cyc++) begin
            if (cyc == 9)  check("drop_err_before", 32'(drop_err), 32'(0));
            if (cyc == 10) bus.lbp_valid = 1'b1;
            step();
            bus.lbp_valid = 1'b0;
            if (bus.hist_valid) seen_valid = 1'b1;
        end
        check("clear_valid_low", 32'(seen_valid), 32'(0));
        check("drop_err_clear", 32'(drop_err), 32'(1));

        // border filtering, back-to-back same bin, backpressured dump
        restart();
        wait_clear();
        send(14'd128, 8'h07, 1'b0);
        send(14'd255, 8'h07, 1'b0);
        send(pix(0, 5), 8'h07, 1'b0);
        send(pix(127, 5), 8'h07, 1'b0);
        for (int r = 1; r <= 126; r++)
            for (int c = 1; c <= 126; c++)
                send(pix(r, c), 8'h00, (r == 126 && c == 126));
        exp_bins[map_code(8'h00)] = 15876;
        check("drop_err_border", 32'(drop_err), 32'(0));
        push_expected();
        run_dump(1'b1, 0);
        check("queue_empty_bp", 32'(exp_q.size()), 32'(0));
        check("hist_done_bp", 32'(hist_done), 32'(1));
        check("words_bp", 32'(words_seen), 32'(NBINS));
        send(pix(5, 5), 8'h00, 1'b1);
        check("drop_err_done", 32'(drop_err), 32'(1));
        check("hist_done_hold", 32'(hist_done), 32'(1));

        // alternating bins, then reset in the middle of the dump
        restart();
        wait_clear();
        send(pix(3, 3), 8'h10, 1'b0);
        send(pix(3, 4), 8'h20, 1'b0);
        send(pix(3, 5), 8'h10, 1'b0);
        send(pix(3, 6), 8'h20, 1'b0);
        finish_only();
        exp_bins[map_code(8'h10)] += 2;
        exp_bins[map_code(8'h20)] += 2;
        push_expected();
        run_dump(1'b0, (NBINS > 100) ? 100 : 30);
        #2 reset = 1'b1;
        #1 check_reset_outputs("mid_dump");
        step();
        reset = 1'b0;
        for (int i = 0; i < 256; i++) exp_bins[i] = 0;
        words_seen = 0;
        bus.hist_ready = 1'b0;
        wait_clear();
        send(pix(64, 64), 8'h03, 1'b0);
        finish_only();
        exp_bins[map_code(8'h03)] = 1;
        push_expected();
        run_dump(1'b0, 0);
        check("queue_empty_rerun", 32'(exp_q.size()), 32'(0));
        check("words_rerun", 32'(words_seen), 32'(NBINS));

        // saturation, mapping of extreme codes, sample in the finish cycle
        restart();
        wait_clear();
        for (k = 0; k < 16390; k++)
            send(pix(1 + (k / 126) % 126, 1 + k % 126), 8'h01, 1'b0);
        send(pix(10, 10), 8'h00, 1'b0);
        send(pix(10, 11), 8'hFF, 1'b0);
        send(pix(10, 12), 8'h05, 1'b1);
        exp_bins[map_code(8'h01)] = 16383;
        exp_bins[map_code(8'h00)] += 1;
        exp_bins[map_code(8'hFF)] += 1;
        exp_bins[map_code(8'h05)] += 1;
        push_expected();
        run_dump(1'b0, 0);
        check("queue_empty_sat", 32'(exp_q.size()), 32'(0));
        check("drop_err_sat", 32'(drop_err), 32'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
